// File: rtl/uart_receiver.sv
// uart_receiver: UART receive controller with 16x oversampling.
//
// Captures start / DATA_BITS data (LSB first) / parity / stop frames from an
// asynchronous serial line. Bit timing comes from the embedded baud_controller,
// which emits one sample_ENABLE pulse per 1/OVERSAMPLE of a bit period.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-high reset
//   baud_select  baud rate code (000..111 = 300 .. 115200), hold stable mid-frame
//   Rx_EN        receiver enable; low forces IDLE and drops any partial frame
//   RxD          serial input, idle high, asynchronous to clk
//   Rx_DATA      last received byte (also updated on errored frames)
//   Rx_VALID     one-clk pulse for an error-free frame
//   Rx_FERROR    sticky framing error (stop bit sampled low)
//   Rx_PERROR    sticky parity error
//
// Sticky flags clear only at the next confirmed start bit or at reset.

// baud_controller: divides clk down to OVERSAMPLE ticks per bit for the
// selected baud rate.
//   clk, reset     clock and asynchronous active-high reset
//   baud_select    baud rate code
//   sample_ENABLE  one-clk tick, OVERSAMPLE per bit period
module baud_controller #(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] baud_select,
  output logic       sample_ENABLE
);

  localparam int CW = 24;

  function automatic int unsigned baud_rate(input int unsigned code);
    case (code)
      0:       return 300;
      1:       return 1200;
      2:       return 4800;
      3:       return 9600;
      4:       return 19200;
      5:       return 38400;
      6:       return 57600;
      default: return 115200;
    endcase
  endfunction

  // Clocks per tick, clamped to 1 so a slow clk still produces ticks.
  function automatic int unsigned divisor(input int unsigned code);
    int unsigned d;
    d = CLK_HZ / (baud_rate(code) * OVERSAMPLE);
    return (d < 1) ? 1 : d;
  endfunction

  logic [CW-1:0] div_table [8];
  logic [CW-1:0] div_limit;
  logic [CW-1:0] div_count;

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_div
      assign div_table[gi] = CW'(divisor(gi));
    end
  endgenerate

  assign div_limit = div_table[baud_select] - CW'(1);

  // ">=" keeps the divider recovering if baud_select shrinks the period.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_count     <= '0;
      sample_ENABLE <= 1'b0;
    end else if (div_count >= div_limit) begin
      div_count     <= '0;
      sample_ENABLE <= 1'b1;
    end else begin
      div_count     <= div_count + CW'(1);
      sample_ENABLE <= 1'b0;
    end
  end

endmodule

module uart_receiver #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned CLK_HZ     = 50_000_000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [2:0]           baud_select,
  input  logic                 Rx_EN,
  input  logic                 RxD,
  output logic [DATA_BITS-1:0] Rx_DATA,
  output logic                 Rx_VALID,
  output logic                 Rx_FERROR,
  output logic                 Rx_PERROR
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic ODD = 1'(PARITY_ODD);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  logic                 sample_ENABLE;
  logic                 rx_meta;
  logic                 rxs;
  logic [2:0]           state;
  logic [TW-1:0]        tick_count;
  logic [BW-1:0]        bit_count;
  logic [DATA_BITS-1:0] shift;
  logic                 parity_acc;
  logic                 perr_pend;
  logic                 stop_bit;
  logic                 frame_done;
  logic                 tick_last;
  logic                 tick_mid;

  baud_controller #(
    .CLK_HZ     (CLK_HZ),
    .OVERSAMPLE (OVERSAMPLE)
  ) u_baud (
    .clk           (clk),
    .reset         (reset),
    .baud_select   (baud_select),
    .sample_ENABLE (sample_ENABLE)
  );

  // Two-flop synchronizer; resets to the idle line level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= RxD;
      rxs     <= rx_meta;
    end
  end

  // Full bit period elapsed: counter about to wrap OVERSAMPLE-1 -> 0.
  assign tick_last = (tick_count == TW'(OVERSAMPLE - 1));
  // The counter is about to reach OVERSAMPLE/2-1: the IDLE tick that saw the
  // falling edge counts as tick 0, so this lands at the middle of the start bit.
  assign tick_mid  = (tick_count == TW'(OVERSAMPLE / 2 - 2));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      tick_count <= '0;
      bit_count  <= '0;
      shift      <= '0;
      parity_acc <= 1'b0;
      perr_pend  <= 1'b0;
      stop_bit   <= 1'b1;
      frame_done <= 1'b0;
      Rx_DATA    <= '0;
      Rx_VALID   <= 1'b0;
      Rx_FERROR  <= 1'b0;
      Rx_PERROR  <= 1'b0;
    end else begin
      Rx_VALID   <= 1'b0;
      frame_done <= 1'b0;

      // Results are published the clk after the stop-bit sample, so the FSM
      // is already back in IDLE and free to catch a back-to-back start bit.
      if (frame_done) begin
        Rx_DATA   <= shift;
        Rx_PERROR <= perr_pend;
        Rx_FERROR <= ~stop_bit;
        Rx_VALID  <= ~perr_pend & stop_bit;
      end

      if (!Rx_EN) begin
        state      <= IDLE;
        tick_count <= '0;
        bit_count  <= '0;
      end else if (sample_ENABLE) begin
        case (state)
          IDLE: begin
            tick_count <= '0;
            if (!rxs) state <= START;
          end

          START: begin
            if (tick_mid) begin
              if (rxs) begin
                // Glitch, not a start bit: leave flags alone.
                state <= IDLE;
              end else begin
                Rx_FERROR  <= 1'b0;
                Rx_PERROR  <= 1'b0;
                tick_count <= '0;
                bit_count  <= '0;
                parity_acc <= 1'b0;
                state      <= DATA;
              end
            end else begin
              tick_count <= tick_count + TW'(1);
            end
          end

          DATA: begin
            if (tick_last) begin
              tick_count <= '0;
              shift      <= {rxs, shift[DATA_BITS-1:1]};
              parity_acc <= parity_acc ^ rxs;
              bit_count  <= bit_count + BW'(1);
              if (bit_count == BW'(DATA_BITS - 1)) state <= PARITY;
            end else begin
              tick_count <= tick_count + TW'(1);
            end
          end

          PARITY: begin
            if (tick_last) begin
              tick_count <= '0;
              perr_pend  <= ((parity_acc ^ rxs) != ODD);
              state      <= STOP;
            end else begin
              tick_count <= tick_count + TW'(1);
            end
          end

          STOP: begin
            if (tick_last) begin
              tick_count <= '0;
              stop_bit   <= rxs;
              frame_done <= 1'b1;
              state      <= IDLE;
            end else begin
              tick_count <= tick_count + TW'(1);
            end
          end

          default: begin
            state      <= IDLE;
            tick_count <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
UART receive controller that sequences serial frame capture using the 16x oversampling tick from baud_controller, which it instantiates internally.
- Detects the start bit, samples 8 data bits at mid-bit, then parity and stop.
- Delivers the byte plus validity and error flags to the system side.
- Sits beside the transmitter in the UART top level and shares the same baud_select encoding.

Parameters:
DATA_BITS, 8, number of data bits per frame, sent LSB first.
OVERSAMPLE, 16, sample_ENABLE ticks per bit period. Must match baud_controller.
PARITY_ODD, 0, 0 selects even parity, 1 selects odd parity.

Ports:
clk  input  1  system clock, all logic on the rising edge.
reset  input  1  asynchronous, active-high reset. Single clock domain.
baud_select  input  3  baud rate code passed to baud_controller (000..111 = 300, 1200, 4800, 9600, 19200, 38400, 57600, 115200).
Rx_EN  input  1  receiver enable. Low forces IDLE.
RxD  input  1  serial line, idle high, asynchronous to clk.
Rx_DATA  output  DATA_BITS  last received byte.
Rx_VALID  output  1  one-clk pulse: error-free frame received.
Rx_FERROR  output  1  framing error flag (stop bit sampled 0).
Rx_PERROR  output  1  parity error flag.

Behaviour:
- Reset (async): state=IDLE, tick counter=0, bit counter=0.
  - Rx_DATA=0, Rx_VALID=0, Rx_FERROR=0, Rx_PERROR=0.
  - Synchronizer flops=1.
- Input path: RxD passes through a 2-FF synchronizer (reset to 1). All decisions use the synchronized value rxs.
- Tick counter (0..OVERSAMPLE-1) advances only on clk edges where sample_ENABLE=1.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - On a tick with Rx_EN=1 and rxs=0: go to START, tick counter=0.
- START:
  - On the tick at which the counter reaches OVERSAMPLE/2-1 (mid start bit):
    - rxs=1: false start, return to IDLE, no flag change.
    - rxs=0: clear Rx_FERROR and Rx_PERROR, tick counter=0, bit counter=0, go to DATA.
- DATA:
  - Every OVERSAMPLE ticks (counter wraps 15->0), sample rxs into the shift register, LSB first. Bit counter increments.
  - After the DATA_BITS-th sample, go to PARITY.
- PARITY:
  - After OVERSAMPLE ticks, sample the parity bit.
  - Error condition: XOR(data bits, parity bit) != PARITY_ODD.
- STOP:
  - After OVERSAMPLE ticks, sample the stop bit.
  - On the following clk: Rx_DATA loads the shift register (also loaded on error).
  - Rx_PERROR is set per the parity check. Rx_FERROR is set if stop=0.
  - Rx_VALID=1 for exactly one clk if neither error is set.
  - State returns to IDLE at mid stop bit, which allows back-to-back frames.
- Error flags are sticky: they hold until the next confirmed start bit or reset. Rx_VALID is never asserted together with either flag.
- Rx_DATA holds its value between frames.
- Rx_EN deasserted in any state: next clk goes to IDLE, partial frame discarded, outputs unchanged.
- reset asserted mid-frame: immediate return to reset values. No Rx_VALID is issued for the aborted frame.
- baud_select must be stable while not in IDLE. Changing it mid-frame is unsupported; the frame content is undefined but the FSM must still return to IDLE.
- Latency: Rx_VALID rises 1 clk after the sample_ENABLE tick that samples the stop bit.

Test Plan:
1. baud_select=111, Rx_EN=1, send 0x55 with parity 0 and stop 1 -> Rx_DATA=0x55, one-clk Rx_VALID, Rx_FERROR=0, Rx_PERROR=0.
2. Send 0xA5 with parity bit 1 (even parity, PARITY_ODD=0) -> Rx_DATA=0xA5, Rx_PERROR=1, Rx_VALID never 1. Then send a good 0x3C -> Rx_PERROR clears at its start bit and Rx_VALID pulses with Rx_DATA=0x3C.
3. Send 0x0F with correct parity and stop bit=0 -> Rx_FERROR=1, Rx_VALID=0, Rx_DATA=0x0F.
4. Drive RxD low for 4 ticks, then high -> FSM returns to IDLE, no Rx_VALID, flags unchanged. A subsequent 0x81 frame is received correctly.
5. Back-to-back 0x00 then 0xFF (parity 0, stop 1, next start immediately after the stop bit) -> two Rx_VALID pulses with Rx_DATA 0x00 then 0xFF.
6. Assert reset during data bit 3 of a frame, release, send 0xC3 -> all outputs 0 during reset, no spurious Rx_VALID, then Rx_DATA=0xC3 valid. Repeat with Rx_EN dropped mid-frame -> frame discarded.
